// File: rtl/eeprom_writer.sv
// rtl/eeprom_writer.sv - Copies a RAM address range into a paged parallel EEPROM.
// Three clocks per byte, then a full write-cycle wait after each page.
module eeprom_writer #(
  parameter logic [15:0] FIRST_ADDR         = 16'h0000,
  parameter logic [15:0] LAST_ADDR          = 16'h7FFF,
  parameter int          PAGE_BYTES         = 32,
  parameter int          WRITE_CYCLE_CLOCKS = 10000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [15:0] address,
  output logic        ram_cs_n,
  output logic        ram_oe_n,
  output logic        eeprom_cs_n,
  output logic        eeprom_we_n,
  output logic        busy,
  output logic        done
);

  localparam int              CNT_W     = $clog2(WRITE_CYCLE_CLOCKS + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WRITE_CYCLE_CLOCKS - 1);
  localparam logic [15:0]     PAGE_MASK = 16'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t           state, next_state;
  logic [15:0]      next_address;
  logic [CNT_W-1:0] wait_cnt, next_wait_cnt;
  logic             last_page, next_last_page;
  logic             next_busy, next_done;
  logic             next_bus_on, next_we_on;

  always_comb begin
    next_state     = state;
    next_address   = address;
    next_wait_cnt  = wait_cnt;
    next_last_page = last_page;
    next_busy      = busy;
    next_done      = done;
    case (state)
      IDLE: begin
        if (start) begin
          next_address   = FIRST_ADDR;
          next_last_page = 1'b0;
          next_busy      = 1'b1;
          next_done      = 1'b0;
          next_state     = SETUP;
        end
      end
      SETUP: next_state = PULSE;
      PULSE: next_state = HOLD;
      HOLD: begin
        next_wait_cnt = '0;
        // The last address never increments, so LAST_ADDR=16'hFFFF cannot wrap.
        if (address == LAST_ADDR) begin
          next_last_page = 1'b1;
          next_state     = WAIT;
        end else begin
          next_address = address + 16'd1;
          if (((address + 16'd1) & PAGE_MASK) == 16'd0) next_state = WAIT;
          else                                          next_state = SETUP;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_wait_cnt = '0;
          if (last_page) begin
            next_busy  = 1'b0;
            next_done  = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = SETUP;
          end
        end else begin
          next_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
    // Strobes are registered from the next state so they line up with it.
    next_bus_on = (next_state == SETUP) || (next_state == PULSE) || (next_state == HOLD);
    next_we_on  = (next_state == PULSE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      address     <= 16'h0000;
      wait_cnt    <= '0;
      last_page   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_cs_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      eeprom_cs_n <= 1'b1;
      eeprom_we_n <= 1'b1;
    end else begin
      state       <= next_state;
      address     <= next_address;
      wait_cnt    <= next_wait_cnt;
      last_page   <= next_last_page;
      busy        <= next_busy;
      done        <= next_done;
      ram_cs_n    <= ~next_bus_on;
      ram_oe_n    <= ~next_bus_on;
      eeprom_cs_n <= ~next_bus_on;
      eeprom_we_n <= ~next_we_on;
    end
  end

endmodule

// File: doc/eeprom_writer.md
EEPROM_WRITER -- requirements
Module: eeprom_writer

Interface
REQ-001 SHALL have parameter FIRST_ADDR, 16'h0000, first address copied.
REQ-002 SHALL have parameter LAST_ADDR, 16'h7FFF, last address copied, inclusive, at or above FIRST_ADDR.
REQ-003 SHALL have parameter PAGE_BYTES, 32, EEPROM page size; a power of 2 from 2 to 64.
REQ-004 SHALL have parameter WRITE_CYCLE_CLOCKS, 10000, clocks of EEPROM internal write wait (10 ms at 1 MHz).
REQ-005 SHALL have port clock, input, 1, single system clock (1 MHz); all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request to copy RAM to EEPROM; sampled at the rising edge.
REQ-008 SHALL have port address, output, 16, shared address to RAM and EEPROM.
REQ-009 SHALL have port ram_cs_n, output, 1, RAM chip select, active low.
REQ-010 SHALL have port ram_oe_n, output, 1, RAM output enable, active low; RAM drives the shared data bus.
REQ-011 SHALL have port eeprom_cs_n, output, 1, EEPROM chip select, active low.
REQ-012 SHALL have port eeprom_we_n, output, 1, EEPROM write strobe, active low; EEPROM latches data on the rising edge.
REQ-013 SHALL have port busy, output, 1, high while a copy is in progress.
REQ-014 SHALL have port done, output, 1, sticky flag: the last copy completed.

Function
REQ-015 SHALL use FSM states IDLE, SETUP, PULSE, HOLD and WAIT; every output is registered.
REQ-016 IDLE: start=1 at an edge SHALL load address=FIRST_ADDR, clear done, set busy and enter SETUP.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 SETUP (1 clk) SHALL drive ram_cs_n=0, ram_oe_n=0, eeprom_cs_n=0 and eeprom_we_n=1.
REQ-019 PULSE (1 clk) SHALL drive the same as SETUP except eeprom_we_n=0.
REQ-020 HOLD (1 clk) SHALL drive the same as SETUP, so address and data are stable across the rising edge of we_n.
REQ-021 Each byte SHALL take exactly 3 clks; a 32-byte page load takes 96 us, under the EEPROM 150 us byte-load limit.
REQ-022 On leaving HOLD with address==LAST_ADDR, the FSM SHALL enter WAIT with a final flag set, and address SHALL hold.
REQ-023 Otherwise, on leaving HOLD, address SHALL increment by 1; the FSM SHALL enter WAIT if (address+1) mod PAGE_BYTES==0, else SETUP.
REQ-024 WAIT SHALL drive ram_cs_n, ram_oe_n, eeprom_cs_n and eeprom_we_n all to 1, and count exactly WRITE_CYCLE_CLOCKS clks.
REQ-025 At the end of WAIT, a non-final page SHALL go to SETUP; the final page SHALL go to IDLE with busy=0 and done=1 on the same edge.
REQ-026 A partial first or last page (unaligned FIRST_ADDR or LAST_ADDR) SHALL still receive a full WAIT.
REQ-027 The address SHALL NOT wrap: LAST_ADDR=16'hFFFF ends at HOLD with no increment.
REQ-028 IDLE SHALL drive all four strobes to 1 and busy=0; address SHALL hold its last value.
REQ-029 eeprom_we_n=0 SHALL occur only in PULSE, and never while eeprom_cs_n=1.
REQ-030 The WAIT counter SHALL be wide enough for WRITE_CYCLE_CLOCKS and reset to 0 on every WAIT entry.

Reset
REQ-031 When reset_n=0, the block SHALL asynchronously set: state IDLE, address 16'h0000, all strobes 1, busy=0, done=0, counter 0.
REQ-032 A reset during PULSE SHALL release eeprom_we_n immediately; the affected page is undefined and the copy is not resumed.
REQ-033 Reset deassertion SHALL leave the block in IDLE, waiting for start.

Verification
(bench parameters: FIRST_ADDR=0, LAST_ADDR=5, PAGE_BYTES=4, WRITE_CYCLE_CLOCKS=8)
REQ-034 Single start pulse -> we_n strobes at addresses 0,1,2,3; 8-clk WAIT; strobes at 4,5; 8-clk WAIT; busy high exactly 34 clks, then done=1.
REQ-035 Per byte -> SETUP/PULSE/HOLD pattern 1/0/1 on we_n, with address and cs stable across all 3 clks; ram_oe_n=0 throughout.
REQ-036 start held high for the whole copy -> only one copy; after done, a still-high start begins a new copy and clears done.
REQ-037 reset_n low mid-PULSE at address 2 -> all strobes 1 and busy=0 with no clock edge; done=0; no further writes.
REQ-038 FIRST_ADDR=16'hFFFE, LAST_ADDR=16'hFFFF -> two writes, one WAIT, address ends 16'hFFFF, no wrap to 0.
REQ-039 An assertion checker SHALL flag any eeprom_we_n=0 with eeprom_cs_n=1 or ram_oe_n=1, and any address change while eeprom_we_n=0.
